// File: rtl/uart_mux_pkg.sv
// uart_mux_pkg
// Shared definitions for the UART receive arbiter:
//   state_e   - arbiter FSM state encoding (IDLE, SEND_TAG, SEND_DATA)
//   idx_width - width of a channel index / tag value for a given channel count
//   BURST_W   - width of the per-grant burst counter (MAX_BURST is at most 255)
package uart_mux_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_TAG  = 2'd1,
        SEND_DATA = 2'd2
    } state_e;

    localparam int unsigned BURST_W = 8;

    // A single channel still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
// Combinational round-robin pick: returns the first requesting index at or after
// the pointer, wrapping modulo N, in a single cycle.
// Ports:
//   i_req   - request vector, one bit per channel
//   i_ptr   - search start index (always < N)
//   o_idx   - selected index (0 when nothing requests)
//   o_valid - high when any request bit is set
module uart_rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    logic [W-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = W'((32'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter
// Round-robin multiplexer of several UART receive FIFOs into one output FIFO.
// Every byte is forwarded as a pair: a tag byte (channel index) then the data byte.
// A grant serves at most MAX_BURST pairs before the pointer moves on.
// Ports:
//   clk, reset      - clock and asynchronous active-high reset
//   rx_empty        - per-channel FIFO empty flags
//   rx_data         - packed FWFT heads, channel i at [i*DATA_BITS +: DATA_BITS]
//   rx_read         - one-hot pop strobe to the channel FIFOs
//   ch_enable       - per-channel arbitration enable mask
//   out_fifo_full   - output FIFO full flag
//   out_fifo_write  - output FIFO push strobe
//   out_fifo_data   - byte pushed (0 when not writing)
//   busy            - FSM not in IDLE
//   grant_index     - channel currently granted
module uart_rx_arbiter
    import uart_mux_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned UART_COUNT = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [UART_COUNT-1:0]             rx_empty,
    input  logic [UART_COUNT*DATA_BITS-1:0]   rx_data,
    output logic [UART_COUNT-1:0]             rx_read,
    input  logic [UART_COUNT-1:0]             ch_enable,
    input  logic                              out_fifo_full,
    output logic                              out_fifo_write,
    output logic [DATA_BITS-1:0]              out_fifo_data,
    output logic                              busy,
    output logic [idx_width(UART_COUNT)-1:0]  grant_index
);

    localparam int unsigned GW = idx_width(UART_COUNT);

    state_e             r_state;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_rr_ptr;
    logic [BURST_W-1:0] r_burst_cnt;

    logic [UART_COUNT-1:0] w_req;
    logic [GW-1:0]         w_pick;
    logic                  w_pick_valid;
    logic                  w_tag_ok;
    logic [GW-1:0]         w_next_ptr;
    logic [BURST_W:0]      w_burst_inc;
    logic                  w_burst_done;

    assign w_req = ch_enable & ~rx_empty;

    uart_rr_pick #(
        .N (UART_COUNT),
        .W (GW)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick),
        .o_valid (w_pick_valid)
    );

    // A tag is only sent if the granted channel still has data and is still enabled;
    // this is where a burst ends early on drain or disable.
    assign w_tag_ok     = ~rx_empty[r_grant] & ch_enable[r_grant];
    assign w_next_ptr   = (r_grant == GW'(UART_COUNT - 1)) ? '0 : r_grant + GW'(1);
    assign w_burst_inc  = {1'b0, r_burst_cnt} + (BURST_W + 1)'(1);
    assign w_burst_done = (w_burst_inc == (BURST_W + 1)'(MAX_BURST));

    // Strobes are combinational so a pair issues at one byte per cycle once granted.
    always_comb begin
        out_fifo_write = 1'b0;
        out_fifo_data  = '0;
        rx_read        = '0;
        case (r_state)
            SEND_TAG: begin
                if (w_tag_ok && !out_fifo_full) begin
                    out_fifo_write = 1'b1;
                    out_fifo_data  = DATA_BITS'(r_grant);
                end
            end
            SEND_DATA: begin
                if (!out_fifo_full) begin
                    out_fifo_write = 1'b1;
                    out_fifo_data  = rx_data[r_grant*DATA_BITS +: DATA_BITS];
                    rx_read        = UART_COUNT'(1) << r_grant;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant     <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= SEND_TAG;
                    end
                end
                SEND_TAG: begin
                    if (!w_tag_ok) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (!out_fifo_full) begin
                        r_state <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    // A started pair always completes, even if the channel was disabled.
                    if (!out_fifo_full) begin
                        r_burst_cnt <= w_burst_inc[BURST_W-1:0];
                        if (w_burst_done) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_state <= SEND_TAG;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign grant_index = r_grant;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb_uart_rx_arbiter
// Self-checking bench: behavioural FWFT channel FIFOs, a scoreboard queue of expected
// output bytes filled as stimulus is driven, a table of single-pair latency vectors and
// hand-written sequences for bursts, back-pressure, masking and reset.
`timescale 1ns/1ps
module tb_uart_rx_arbiter;

    localparam int unsigned DB = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NC-1:0] rx_empty;
    logic [NC*DB-1:0] rx_data;
    logic [NC-1:0] rx_read;
    logic [NC-1:0] ch_enable = '0;
    logic          out_fifo_full = 1'b0;
    logic          out_fifo_write;
    logic [DB-1:0] out_fifo_data;
    logic          busy;
    logic [1:0]    grant_index;

    uart_rx_arbiter #(
        .DATA_BITS  (DB),
        .UART_COUNT (NC),
        .MAX_BURST  (MB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_empty       (rx_empty),
        .rx_data        (rx_data),
        .rx_read        (rx_read),
        .ch_enable      (ch_enable),
        .out_fifo_full  (out_fifo_full),
        .out_fifo_write (out_fifo_write),
        .out_fifo_data  (out_fifo_data),
        .busy           (busy),
        .grant_index    (grant_index)
    );

    always #5 clk = ~clk;

    // Channel FIFO model; head doubles as the per-channel pop count.
    logic [7:0]  mem  [NC][32];
    int unsigned head [NC] = '{default: 0};
    int unsigned tail [NC] = '{default: 0};

    always_comb begin
        rx_empty = '0;
        rx_data  = '0;
        for (int i = 0; i < NC; i++) begin
            rx_empty[i]       = (head[i] == tail[i]);
            rx_data[i*8 +: 8] = mem[i][head[i] % 32];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rx_read[i]) head[i] <= head[i] + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    logic          s_write;
    logic [7:0]    s_data;
    logic [NC-1:0] s_read;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fifo_push(input int unsigned ch, input logic [7:0] d);
        mem[ch][tail[ch] % 32] = d;
        tail[ch] = tail[ch] + 1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    // Per-cycle scoreboard and protocol checks, sampled on the falling edge.
    task automatic monitor();
        logic [NC-1:0] one;
        one     = 4'b0001;
        s_write = out_fifo_write;
        s_data  = out_fifo_data;
        s_read  = rx_read;
        if (!reset) begin
            if (out_fifo_write) begin
                check("no_write_while_full", {31'b0, out_fifo_full}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write (t=%0t)",
                             out_fifo_data, $time);
                end else begin
                    check("out_byte", {24'b0, out_fifo_data}, {24'b0, exp_q.pop_front()});
                end
            end else begin
                check("data_zero_without_write", {24'b0, out_fifo_data}, 32'd0);
            end
            if (rx_read != '0) begin
                check("pop_onehot", {28'b0, rx_read}, {28'b0, one << grant_index});
                check("pop_with_write", {31'b0, out_fifo_write}, 32'd1);
                check("assert_grant_not_empty_in_data", {31'b0, rx_empty[grant_index]}, 32'd0);
            end
        end
    endtask

    // Returns in the drive window just after a rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            if (!busy && ((ch_enable & ~rx_empty) == '0)) done = 1'b1;
        end
        check("idle_reached", {31'b0, done}, 32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    task automatic poll_tag(input logic [7:0] tag, input int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            tick();
            if (s_write && s_data == tag) found = 1'b1;
        end
        check("tag_seen", {31'b0, found}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int unsigned ch;
        logic [7:0]  data;
        logic [7:0]  exp_tag;
        logic [7:0]  exp_data;
        logic [3:0]  exp_pop;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int unsigned h;
        bit found;

        vecs[0] = '{ch: 0, data: 8'h11, exp_tag: 8'h00, exp_data: 8'h11, exp_pop: 4'b0001};
        vecs[1] = '{ch: 1, data: 8'h22, exp_tag: 8'h01, exp_data: 8'h22, exp_pop: 4'b0010};
        vecs[2] = '{ch: 3, data: 8'hFF, exp_tag: 8'h03, exp_data: 8'hFF, exp_pop: 4'b1000};
        vecs[3] = '{ch: 2, data: 8'h00, exp_tag: 8'h02, exp_data: 8'h00, exp_pop: 4'b0100};
        vecs[4] = '{ch: 3, data: 8'h80, exp_tag: 8'h03, exp_data: 8'h80, exp_pop: 4'b1000};
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < 32; j++) mem[i][j] = 8'h00;
        end

        // Reset state with a request pending, then channel 2 with two bytes.
        ch_enable = 4'hF;
        fifo_push(2, 8'hA5);
        fifo_push(2, 8'h5A);
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_write", {31'b0, out_fifo_write}, 32'd0);
        check("rst_read", {28'b0, rx_read}, 32'd0);
        check("rst_grant", {30'b0, grant_index}, 32'd0);
        check("rst_data", {24'b0, out_fifo_data}, 32'd0);
        expect_byte(8'h02); expect_byte(8'hA5); expect_byte(8'h02); expect_byte(8'h5A);
        reset = 1'b0;
        wait_idle(40);
        check("ch2_pops", head[2], 32'd2);
        check("ch2_busy_after", {31'b0, busy}, 32'd0);

        // Single-pair latency vectors: idle cycle, tag at t+1, data at t+2.
        for (int v = 0; v < 5; v++) begin
            expect_byte(vecs[v].exp_tag);
            expect_byte(vecs[v].exp_data);
            fifo_push(vecs[v].ch, vecs[v].data);
            tick();
            check("lat_idle", {31'b0, s_write}, 32'd0);
            tick();
            check("lat_tag", {23'b0, s_write, s_data}, {23'b0, 1'b1, vecs[v].exp_tag});
            tick();
            check("lat_data", {23'b0, s_write, s_data}, {23'b0, 1'b1, vecs[v].exp_data});
            check("lat_pop", {28'b0, s_read}, {28'b0, vecs[v].exp_pop});
            wait_idle(20);
        end

        // Round robin over all channels, then the pointer wraps back to 0.
        do_reset();
        ch_enable = 4'h0;
        for (int c = 0; c < NC; c++) begin
            fifo_push(c, 8'hB0 + 8'(c));
            expect_byte(8'(c));
            expect_byte(8'hB0 + 8'(c));
        end
        ch_enable = 4'hF;
        wait_idle(60);
        fifo_push(3, 8'hC3);
        fifo_push(0, 8'hC0);
        expect_byte(8'h00); expect_byte(8'hC0); expect_byte(8'h03); expect_byte(8'hC3);
        wait_idle(40);

        // Burst limit: 4 from ch1, 1 from ch3, remaining 2 from ch1.
        do_reset();
        ch_enable = 4'h0;
        h = head[1];
        for (int k = 0; k < 6; k++) fifo_push(1, 8'h10 + 8'(k));
        fifo_push(3, 8'h30);
        for (int k = 0; k < 4; k++) begin
            expect_byte(8'h01); expect_byte(8'h10 + 8'(k));
        end
        expect_byte(8'h03); expect_byte(8'h30);
        for (int k = 4; k < 6; k++) begin
            expect_byte(8'h01); expect_byte(8'h10 + 8'(k));
        end
        ch_enable = 4'hF;
        wait_idle(80);
        check("ch1_burst_pops", head[1] - h, 32'd6);

        // Back-pressure in SEND_DATA for 5 cycles.
        h = head[2];
        expect_byte(8'h02); expect_byte(8'h9C);
        fifo_push(2, 8'h9C);
        tick();
        tick();
        check("full_tag_first", {23'b0, s_write, s_data}, {23'b0, 1'b1, 8'h02});
        out_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("full_no_write", {31'b0, s_write}, 32'd0);
            check("full_no_pop", {28'b0, s_read}, 32'd0);
            check("full_busy", {31'b0, busy}, 32'd1);
        end
        out_fifo_full = 1'b0;
        tick();
        check("full_release_data", {23'b0, s_write, s_data}, {23'b0, 1'b1, 8'h9C});
        wait_idle(20);
        check("full_single_pop", head[2] - h, 32'd1);

        // Masked channel never granted; re-enable serves it within 2 cycles.
        ch_enable = 4'b1101;
        h = head[1];
        expect_byte(8'h00); expect_byte(8'h70);
        fifo_push(1, 8'h77);
        fifo_push(0, 8'h70);
        wait_idle(30);
        check("masked_no_pop", head[1] - h, 32'd0);
        check("masked_still_full", {31'b0, rx_empty[1]}, 32'd0);
        expect_byte(8'h01); expect_byte(8'h77);
        ch_enable = 4'hF;
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            tick();
            if (s_write && s_data == 8'h01) found = 1'b1;
        end
        check("reenable_latency", {31'b0, found}, 32'd1);
        wait_idle(20);

        // Disable mid-pair: the pair completes, the burst ends at the next tag.
        h = head[0];
        expect_byte(8'h00); expect_byte(8'hE0);
        fifo_push(0, 8'hE0); fifo_push(0, 8'hE1); fifo_push(0, 8'hE2);
        poll_tag(8'h00, 10);
        ch_enable = 4'b1110;
        tick();
        check("disable_pair_completes", {23'b0, s_write, s_data}, {23'b0, 1'b1, 8'hE0});
        wait_idle(20);
        check("disable_one_pop", head[0] - h, 32'd1);
        expect_byte(8'h00); expect_byte(8'hE1); expect_byte(8'h00); expect_byte(8'hE2);
        ch_enable = 4'hF;
        wait_idle(40);

        // Reset in SEND_DATA: pair abandoned, search restarts from channel 0.
        ch_enable = 4'b1000;
        h = head[3];
        expect_byte(8'h03);
        fifo_push(1, 8'h11);
        fifo_push(3, 8'h33);
        poll_tag(8'h03, 10);
        reset = 1'b1;
        #1;
        check("midrst_write", {31'b0, out_fifo_write}, 32'd0);
        check("midrst_read", {28'b0, rx_read}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_grant", {30'b0, grant_index}, 32'd0);
        tick();
        tick();
        check("midrst_no_pop", head[3] - h, 32'd0);
        reset = 1'b0;
        expect_byte(8'h01); expect_byte(8'h11); expect_byte(8'h03); expect_byte(8'h33);
        ch_enable = 4'hF;
        wait_idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_arbiter.md
UART_RX_ARBITER -- requirements
Module: uart_rx_arbiter

Interface
REQ-001 Parameter DATA_BITS, 8, width of every data byte and tag byte.
REQ-002 Parameter UART_COUNT, 4, number of receive channels; legal range 2..2**DATA_BITS.
REQ-003 Parameter MAX_BURST, 4, maximum bytes forwarded from one channel per grant; legal range 1..255.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port rx_empty, input, UART_COUNT, per-channel receive FIFO empty flag.
REQ-007 Port rx_data, input, UART_COUNT*DATA_BITS, packed first-word-fall-through heads; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-008 Port rx_read, output, UART_COUNT, one-hot pop strobe to channel FIFOs.
REQ-009 Port ch_enable, input, UART_COUNT, per-channel arbitration enable mask.
REQ-010 Port out_fifo_full, input, 1, output FIFO full flag.
REQ-011 Port out_fifo_write, output, 1, output FIFO push strobe.
REQ-012 Port out_fifo_data, output, DATA_BITS, byte pushed to output FIFO.
REQ-013 Port busy, output, 1, high when the state is not IDLE.
REQ-014 Port grant_index, output, clog2(UART_COUNT), registered index of the channel currently granted.

Function
REQ-015 The block SHALL forward each received byte as a pair: tag byte (grant_index zero-extended to DATA_BITS), then the data byte.
REQ-016 The FSM SHALL have the states IDLE, SEND_TAG and SEND_DATA.
REQ-017 In IDLE, request vector = ch_enable & ~rx_empty; if it is nonzero, the block SHALL register grant = first requesting index at or after rr_ptr (wrapping modulo UART_COUNT), clear burst_cnt, and go to SEND_TAG in one cycle, irrespective of how many channels are skipped.
REQ-018 In SEND_TAG, if rx_empty[grant] or ~ch_enable[grant], the block SHALL go to IDLE with rr_ptr = grant+1 (wrapped) and write nothing.
REQ-019 In SEND_TAG otherwise, when ~out_fifo_full, the block SHALL assert out_fifo_write with the tag and go to SEND_DATA; when full, it SHALL hold with out_fifo_write=0.
REQ-020 In SEND_DATA, when ~out_fifo_full, the block SHALL in the same cycle assert out_fifo_write with the rx_data slice of grant, assert rx_read[grant] only, and increment burst_cnt; when full, it SHALL hold with no strobes.
REQ-021 After an accepted data byte, if burst_cnt+1 == MAX_BURST the block SHALL go to IDLE with rr_ptr = grant+1 (wrapped); otherwise it SHALL go to SEND_TAG with the same grant.
REQ-022 out_fifo_write and rx_read SHALL be combinational on state, grant and out_fifo_full, and SHALL never be asserted while out_fifo_full=1.
REQ-023 Latency: a byte whose channel is non-empty in IDLE at cycle t SHALL have its tag written at t+1 and its data at t+2 with full low; peak throughput is one byte per 2 cycles.
REQ-024 rr_ptr wrap: grant = UART_COUNT-1 SHALL yield rr_ptr = 0.
REQ-025 Disabling a channel mid-burst SHALL end the burst at the next SEND_TAG; a pair already begun SHALL complete.
REQ-026 Only this block pops the channel FIFOs, so rx_empty[grant] SHALL not rise during SEND_DATA; the bench SHALL check this as an assertion.
REQ-027 out_fifo_data SHALL be 0 whenever out_fifo_write=0.

Reset
REQ-028 While reset is high: state=IDLE, rr_ptr=0, grant=0, burst_cnt=0; out_fifo_write=0, rx_read=0, busy=0, grant_index=0.
REQ-029 Reset asserted mid-pair SHALL abandon the pair with no further writes or pops; the first grant after release SHALL start the search from channel 0.

Structure
REQ-030 Package uart_mux_pkg SHALL hold the FSM state encoding and the tag-width constant function.
REQ-031 Sub-module uart_rr_pick SHALL contain the combinational round-robin pick (request vector, pointer -> index, valid).

Verification
REQ-032 UART_COUNT=4, MAX_BURST=4: channel 2 holds 0xA5 and 0x5A, all others empty -> out bytes 0x02,0xA5,0x02,0x5A; two rx_read[2] pulses; then busy=0.
REQ-033 All 4 channels hold 1 byte, rr_ptr=0 -> tag order 0,1,2,3, then the pointer wraps and channel 0 is served first again.
REQ-034 Channel 1 holds 6 bytes, channel 3 holds 1 byte, MAX_BURST=4 -> 4 pairs from channel 1, 1 pair from channel 3, then 2 pairs from channel 1.
REQ-035 out_fifo_full held high for 5 cycles in SEND_DATA -> no write or pop during those cycles; the data byte is written once on the cycle after full falls.
REQ-036 ch_enable[1]=0 with channel 1 non-empty -> channel 1 is never granted; re-enabling it resumes service within 2 cycles of IDLE.
REQ-037 reset pulsed in SEND_DATA -> all strobes 0 immediately; after release the first tag written is the lowest requesting index.
